// File: rtl/fnd_scan_mux.sv
// Time-multiplexed common-anode 7-segment driver: shadowed hex word, per-digit decode,
// blanking, decimal point and a guard gap between digits. FND_LZ_SUPPRESS_EN enables leading-zero blanking.
module fnd_scan_mux #(
  parameter int unsigned  NUM_DIGITS     = 4,
  parameter int unsigned  SCAN_DIV       = 50000,
  parameter int unsigned  GUARD_CYCLES   = 16,
  parameter bit           COM_ACTIVE_LOW = 1'b1,
  localparam int unsigned IDX_W          = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] number,
  input  logic [NUM_DIGITS-1:0]   blank,
  input  logic [NUM_DIGITS-1:0]   dp,
  output logic [6:0]              fnd_on,
  output logic                    fnd_dp,
  output logic [NUM_DIGITS-1:0]   fnd_com,
  output logic [IDX_W-1:0]        scan_idx
);

  // A zero guard still costs one cycle so commons never overlap.
  localparam int unsigned GLEN  = (GUARD_CYCLES == 0) ? 1 : GUARD_CYCLES;
  localparam int unsigned CMAX  = (SCAN_DIV > GLEN) ? SCAN_DIV : GLEN;
  localparam int unsigned CNT_W = $clog2(CMAX);

  localparam logic [CNT_W-1:0]      SCAN_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0]      GUARD_LAST = CNT_W'(GLEN - 1);
  localparam logic [IDX_W-1:0]      IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] COM_OFF    = {NUM_DIGITS{COM_ACTIVE_LOW}};

  typedef enum logic {ST_GUARD, ST_DRIVE} state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] num_q;
  logic [NUM_DIGITS-1:0]   blank_q, dp_q;
  logic [6:0]              on_q, on_d;
  logic                    dpo_q, dpo_d;
  logic [NUM_DIGITS-1:0]   com_q, com_d;

  logic [NUM_DIGITS-1:0]   dark_vec;
  logic [NUM_DIGITS-1:0]   sel_onehot;
  logic [3:0]              sel_nib;
  logic                    sel_dark, sel_dp;
  logic [6:0]              drv_on;
  logic                    drv_dp;
  logic [NUM_DIGITS-1:0]   drv_com;

  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    case (nib)
      4'h0: seg_decode = 7'h40;
      4'h1: seg_decode = 7'h79;
      4'h2: seg_decode = 7'h24;
      4'h3: seg_decode = 7'h30;
      4'h4: seg_decode = 7'h19;
      4'h5: seg_decode = 7'h12;
      4'h6: seg_decode = 7'h02;
      4'h7: seg_decode = 7'h58;
      4'h8: seg_decode = 7'h00;
      4'h9: seg_decode = 7'h10;
      4'hA: seg_decode = 7'h08;
      4'hB: seg_decode = 7'h03;
      4'hC: seg_decode = 7'h46;
      4'hD: seg_decode = 7'h21;
      4'hE: seg_decode = 7'h06;
      default: seg_decode = 7'h0E;
    endcase
  endfunction

`ifdef FND_LZ_SUPPRESS_EN
  logic [NUM_DIGITS-1:0] lz_vec;
  logic                  zero_run;

  // Walk down from the top digit; a digit is suppressed while everything above it is zero.
  always_comb begin
    zero_run = 1'b1;
    lz_vec   = '0;
    for (int i = int'(NUM_DIGITS) - 1; i > 0; i--) begin
      zero_run  = zero_run & (num_q[4*i +: 4] == 4'h0);
      lz_vec[i] = zero_run & ~dp_q[i];
    end
  end

  assign dark_vec = blank_q | lz_vec;
`else
  assign dark_vec = blank_q;
`endif

  // Select the shadow data of the digit being scanned.
  always_comb begin
    sel_onehot = '0;
    sel_nib    = 4'h0;
    sel_dark   = 1'b0;
    sel_dp     = 1'b0;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      if (idx_q == IDX_W'(i)) begin
        sel_onehot[i] = 1'b1;
        sel_nib       = num_q[4*i +: 4];
        sel_dark      = dark_vec[i];
        sel_dp        = dp_q[i];
      end
    end
    drv_on  = sel_dark ? 7'h7F : seg_decode(sel_nib);
    drv_dp  = sel_dark | ~sel_dp;
    drv_com = COM_ACTIVE_LOW ? ~sel_onehot : sel_onehot;
  end

  // Next state and next registered outputs; guard outputs are the default.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    on_d    = 7'h7F;
    dpo_d   = 1'b1;
    com_d   = COM_OFF;
    case (state_q)
      ST_GUARD: begin
        if (cnt_q == GUARD_LAST) begin
          state_d = ST_DRIVE;
          cnt_d   = '0;
          on_d    = drv_on;
          dpo_d   = drv_dp;
          com_d   = drv_com;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DRIVE: begin
        if (cnt_q == SCAN_LAST) begin
          state_d = ST_GUARD;
          cnt_d   = '0;
          idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          on_d  = drv_on;
          dpo_d = drv_dp;
          com_d = drv_com;
        end
      end
      default: state_d = ST_GUARD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_GUARD;
      cnt_q   <= '0;
      idx_q   <= '0;
      num_q   <= '0;
      blank_q <= '0;
      dp_q    <= '0;
      on_q    <= 7'h7F;
      dpo_q   <= 1'b1;
      com_q   <= COM_OFF;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      on_q    <= on_d;
      dpo_q   <= dpo_d;
      com_q   <= com_d;
      if (load) begin
        num_q   <= number;
        blank_q <= blank;
        dp_q    <= dp;
      end
    end
  end

  assign fnd_on   = on_q;
  assign fnd_dp   = dpo_q;
  assign fnd_com  = com_q;
  assign scan_idx = idx_q;

endmodule
